// File: rtl/io_bus_master.sv
// rtl/io_bus_master.sv - Z80-style I/O bus cycle master with wait states and timeout
module io_bus_master #(
  parameter logic [7:0] MAX_WAIT = 8'd255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_wr,
  input  logic [7:0] cmd_addr,
  input  logic [7:0] cmd_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_timeout,
  output logic       iorq_n,
  output logic       rd_n,
  output logic       wr_n,
  output logic [7:0] addr,
  output logic [7:0] DO,
  input  logic [7:0] DI,
  input  logic       wait_n
);

  typedef enum logic [2:0] {IDLE, T1, T2, TW, T3} state_t;

  state_t     state, next_state;
  logic       wr_q;
  logic [7:0] wait_cnt;
  logic       tw_first;

  logic       accept;
  logic       stall;
  logic       timeout_hit;
  logic       strobe_on;

  logic       cmd_ready_d, rsp_valid_d, rsp_timeout_d;
  logic       iorq_n_d, rd_n_d, wr_n_d;
  logic [7:0] rsp_rdata_d, addr_d, do_d;

  assign accept = (state == IDLE) && cmd_valid && cmd_ready;
  assign stall  = (state == TW) && !wait_n;
  // The first TW cycle is the mandatory one; stalls are counted from the
  // second TW sample onward, so the timeout fires when the count is exhausted.
  assign timeout_hit = stall && !tw_first && (wait_cnt == MAX_WAIT);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // Next-state decode
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept) next_state = T1;
      T1:      next_state = T2;
      T2:      next_state = TW;
      TW:      if (wait_n || timeout_hit) next_state = T3;
      T3:      next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Next values of the registered outputs, derived from the state being entered
  always_comb begin
    strobe_on     = (next_state == T2) || (next_state == TW);
    cmd_ready_d   = (next_state == IDLE);
    iorq_n_d      = !strobe_on;
    rd_n_d        = !(strobe_on && !wr_q);
    wr_n_d        = !(strobe_on && wr_q);
    rsp_valid_d   = (next_state == T3);
    rsp_timeout_d = timeout_hit;
    addr_d        = accept ? cmd_addr : addr;
    do_d          = (accept && cmd_wr) ? cmd_wdata : DO;
    rsp_rdata_d   = rsp_rdata;
    if ((state == TW) && (next_state == T3) && !wr_q)
      rsp_rdata_d = timeout_hit ? 8'hFF : DI;
  end

  // Output registers; reset forces the bus idle without waiting for a clock
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmd_ready   <= 1'b0;
      iorq_n      <= 1'b1;
      rd_n        <= 1'b1;
      wr_n        <= 1'b1;
      addr        <= 8'h00;
      DO          <= 8'h00;
      rsp_valid   <= 1'b0;
      rsp_timeout <= 1'b0;
      rsp_rdata   <= 8'h00;
    end else begin
      cmd_ready   <= cmd_ready_d;
      iorq_n      <= iorq_n_d;
      rd_n        <= rd_n_d;
      wr_n        <= wr_n_d;
      addr        <= addr_d;
      DO          <= do_d;
      rsp_valid   <= rsp_valid_d;
      rsp_timeout <= rsp_timeout_d;
      rsp_rdata   <= rsp_rdata_d;
    end
  end

  // Command direction latch and wait-state counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q     <= 1'b0;
      wait_cnt <= 8'h00;
      tw_first <= 1'b0;
    end else begin
      if (accept) wr_q <= cmd_wr;
      if (state == T2) begin
        wait_cnt <= 8'h00;
        tw_first <= 1'b1;
      end else if (stall && !timeout_hit) begin
        if (tw_first) tw_first <= 1'b0;
        else          wait_cnt <= wait_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_io_bus_master.sv
// tb/tb_io_bus_master.sv - scoreboard bench for io_bus_master
module tb_io_bus_master;

  logic       clk = 1'b0;
  logic       reset;
  logic       cmd_valid, cmd_ready, cmd_wr;
  logic [7:0] cmd_addr, cmd_wdata;
  logic       rsp_valid, rsp_timeout;
  logic [7:0] rsp_rdata;
  logic       iorq_n, rd_n, wr_n;
  logic [7:0] addr, bus_do, bus_di;
  logic       wait_n;

  io_bus_master #(.MAX_WAIT(8'd4)) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_timeout(rsp_timeout),
    .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n),
    .addr(addr), .DO(bus_do), .DI(bus_di), .wait_n(wait_n)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       wr;
    logic [7:0] a;
    logic [7:0] wd;
    logic [7:0] rd;
    logic       to;
    int         lat;
    int         strb;
    int         acc;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  int   strb_cnt = 0, rd_cnt = 0, wr_cnt = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: counts strobe-low cycles and checks each completion against the queue
  always @(negedge clk) begin
    if (reset) begin
      strb_cnt = 0; rd_cnt = 0; wr_cnt = 0;
    end else begin
      if (!iorq_n) strb_cnt++;
      if (!rd_n)   rd_cnt++;
      if (!wr_n)   wr_cnt++;
      if (!rd_n && !wr_n) chk("rd_wr_both_low", 1, 0);
      if (!rsp_valid) begin
        if (rsp_timeout) chk("timeout_without_valid", int'(rsp_timeout), 0);
      end else if (sb.size() == 0) begin
        chk("unexpected_rsp", 1, 0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("latency", cyc - e.acc + 1, e.lat);
        chk("rsp_rdata", int'(rsp_rdata), int'(e.rd));
        chk("rsp_timeout", int'(rsp_timeout), int'(e.to));
        chk("iorq_low_cycles", strb_cnt, e.strb);
        chk("rd_low_cycles", rd_cnt, e.wr ? 0 : e.strb);
        chk("wr_low_cycles", wr_cnt, e.wr ? e.strb : 0);
        chk("t3_strobes_high", int'({iorq_n, rd_n, wr_n}), 7);
        chk("t3_addr_held", int'(addr), int'(e.a));
        if (e.wr) chk("t3_do_held", int'(bus_do), int'(e.wd));
        strb_cnt = 0; rd_cnt = 0; wr_cnt = 0;
      end
    end
  end

  task automatic wait_ready(output logic ok);
    int guard;
    guard = 0;
    while (!cmd_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    ok = cmd_ready;
    if (!ok) chk("cmd_ready_wait_bound", 0, 1);
  endtask

  // nw = number of wait_n=0 samples in TW before wait_n returns high
  task automatic issue(input logic wr, input logic [7:0] a, input logic [7:0] wd,
                       input logic [7:0] di, input int nw, input logic [7:0] exp_rd,
                       input logic exp_to, input int exp_lat, input int exp_strb);
    logic ok;
    exp_t e;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_wr = wr; cmd_addr = a; cmd_wdata = wd;
    wait_ready(ok);
    if (!ok) begin
      cmd_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    e.wr = wr; e.a = a; e.wd = wd; e.rd = exp_rd; e.to = exp_to;
    e.lat = exp_lat; e.strb = exp_strb; e.acc = cyc;
    sb.push_back(e);
    wait_n = (nw == 0);
    bus_di = (nw == 0) ? di : 8'hEE;
    @(negedge clk);
    cmd_valid = 1'b0;
    cmd_addr  = 8'h00;
    cmd_wdata = 8'h00;
    if (nw > 0) begin
      repeat (2 + nw) @(negedge clk);
      wait_n = 1'b1;
      bus_di = di;
    end
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (sb.size() != 0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    chk("scoreboard_drained", sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int   acc1, acc2;
    logic ok;
    reset = 1'b1; cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = 8'h00;
    cmd_wdata = 8'h00; bus_di = 8'h00; wait_n = 1'b1;
    #1;
    chk("reset_cmd_ready", int'(cmd_ready), 0);
    chk("reset_strobes", int'({iorq_n, rd_n, wr_n}), 7);
    chk("reset_addr", int'(addr), 0);
    chk("reset_do", int'(bus_do), 0);
    chk("reset_rdata", int'(rsp_rdata), 0);
    chk("reset_rsp_valid", int'(rsp_valid), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1 chk("ready_before_edge", int'(cmd_ready), 0);
    @(posedge clk); #1;
    chk("ready_after_release", int'(cmd_ready), 1);

    // write 81/41, no waits
    issue(1'b1, 8'h81, 8'h41, 8'h00, 0, 8'h00, 1'b0, 4, 2);
    // read 90, DI=5A, no waits
    issue(1'b0, 8'h90, 8'h00, 8'h5A, 0, 8'h5A, 1'b0, 4, 2);
    // read 93, three stall samples then DI=C3
    issue(1'b0, 8'h93, 8'h00, 8'hC3, 3, 8'hC3, 1'b0, 7, 5);
    // read A0 with wait_n held low past MAX_WAIT=4
    issue(1'b0, 8'hA0, 8'h00, 8'h12, 20, 8'hFF, 1'b1, 9, 7);
    // write leaves rsp_rdata unchanged
    issue(1'b1, 8'h10, 8'h22, 8'h00, 0, 8'hFF, 1'b0, 4, 2);
    drain();

    // back-to-back writes with cmd_valid held high
    @(negedge clk);
    cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 8'h55; cmd_wdata = 8'hAA;
    wait_ready(ok);
    @(posedge clk); #1;
    acc1 = cyc;
    sb.push_back('{1'b1, 8'h55, 8'hAA, 8'hFF, 1'b0, 4, 2, acc1});
    @(negedge clk);
    cmd_addr = 8'h56; cmd_wdata = 8'hBB;
    wait_ready(ok);
    @(posedge clk); #1;
    acc2 = cyc;
    sb.push_back('{1'b1, 8'h56, 8'hBB, 8'hFF, 1'b0, 4, 2, acc2});
    chk("b2b_accept_spacing", acc2 - acc1, 5);
    @(negedge clk);
    cmd_valid = 1'b0;
    drain();

    // reset asserted during T2 of a write
    @(negedge clk);
    cmd_valid = 1'b1; cmd_wr = 1'b1; cmd_addr = 8'h77; cmd_wdata = 8'h33;
    wait_ready(ok);
    @(posedge clk); #1;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("t2_wr_n_low", int'(wr_n), 0);
    reset = 1'b1;
    #1;
    chk("async_reset_strobes", int'({iorq_n, rd_n, wr_n}), 7);
    chk("async_reset_addr", int'(addr), 0);
    chk("async_reset_ready", int'(cmd_ready), 0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1 chk("ready_before_edge_2", int'(cmd_ready), 0);
    @(posedge clk); #1;
    chk("ready_after_release_2", int'(cmd_ready), 1);

    // recovery read after the aborted cycle
    issue(1'b0, 8'h42, 8'h00, 8'h99, 0, 8'h99, 1'b0, 4, 2);
    drain();
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
